// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified byte-addressable memory.
package mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } wr_state_e;

  // Requests of 5..7 bytes behave as a full word.
  function automatic logic [2:0] clamp_size(input logic [2:0] req);
    logic [2:0] n;
    if (req > 3'd4) begin
      n = 3'd4;
    end else begin
      n = req;
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_read_port.sv
// Combinational little-endian 4-byte gather from the byte array,
// wrapping past the top byte back to index 0.
module mem_read_port
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 32
) (
  input  byte_t             mem [DEPTH_BYTES],
  input  logic [ADDR_W-1:0] addr,
  output word_t             data
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  logic [IDX_W-1:0]  idx_s;
  logic [ADDR_W-1:0] unused_addr_s;

  assign unused_addr_s = addr;

  // Gather bytes; the index width truncation provides the wrap.
  always_comb begin
    data  = '0;
    idx_s = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      idx_s           = addr[IDX_W-1:0] + IDX_W'(k);
      data[8*k +: 8]  = mem[idx_s];
    end
  end

endmodule

// File: rtl/main_memory.sv
// Unified CPU memory: two asynchronous 32-bit read ports and one
// 1/2/4-byte write port with a two-state done handshake.
module main_memory
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] instruction_addr,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic [2:0]        bytes_to_write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [31:0]       write_data,
  input  logic              write_activate,
  output logic              write_done,
  output logic [31:0]       instruction_data,
  output logic [31:0]       fetched_data
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);

  byte_t data [DEPTH_BYTES];

  wr_state_e         state_q, state_d;
  logic              write_done_q, write_done_d;
  logic              commit_s;
  logic [2:0]        size_s;
  logic [WORD_BYTES-1:0] wr_en_s;
  logic [IDX_W-1:0]  wr_idx_s [WORD_BYTES];
  logic [ADDR_W-1:0] unused_waddr_s;

  assign size_s         = clamp_size(bytes_to_write);
  assign unused_waddr_s = write_addr;

  // Next-state logic; request inputs only matter in IDLE, reset blocks commits.
  always_comb begin
    state_d      = state_q;
    write_done_d = 1'b0;
    commit_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && write_activate && (size_s != 3'd0)) begin
          commit_s     = 1'b1;
          write_done_d = 1'b1;
          state_d      = DONE;
        end else begin
          state_d      = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write FSM state and registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      write_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_done_q <= write_done_d;
    end
  end

  // Per-byte write enables and wrapped target indices.
  always_comb begin
    for (int k = 0; k < WORD_BYTES; k++) begin
      wr_idx_s[k] = write_addr[IDX_W-1:0] + IDX_W'(k);
      if (commit_s && (3'(k) < size_s)) begin
        wr_en_s[k] = 1'b1;
      end else begin
        wr_en_s[k] = 1'b0;
      end
    end
  end

  // Byte storage; deliberately not reset so a preloaded image survives.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (wr_en_s[k]) begin
        data[wr_idx_s[k]] <= write_data[8*k +: 8];
      end
    end
  end

  assign write_done = write_done_q;

  mem_read_port #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .ADDR_W      (ADDR_W)
  ) u_ifetch_port (
    .mem  (data),
    .addr (instruction_addr),
    .data (instruction_data)
  );

  mem_read_port #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .ADDR_W      (ADDR_W)
  ) u_load_port (
    .mem  (data),
    .addr (fetch_addr),
    .data (fetched_data)
  );

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: directed steps plus randomized
// writes/reads against a byte-array reference model.
module tb_main_memory;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction_addr;
  logic [31:0] fetch_addr;
  logic [2:0]  bytes_to_write;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic        write_activate;
  logic        write_done;
  logic [31:0] instruction_data;
  logic [31:0] fetched_data;

  logic [7:0]  ref_mem [DEPTH];
  int          vectors     = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  main_memory #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .instruction_addr (instruction_addr),
    .fetch_addr       (fetch_addr),
    .bytes_to_write   (bytes_to_write),
    .write_addr       (write_addr),
    .write_data       (write_data),
    .write_activate   (write_activate),
    .write_done       (write_done),
    .instruction_data (instruction_data),
    .fetched_data     (fetched_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[(a + k) % DEPTH];
    return w;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int k = 0; k < n; k++) ref_mem[(a + k) % DEPTH] = d[8*k +: 8];
  endtask

  // One request; expects the done pulse right after the first edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] sz, input string tag);
    int n;
    int first;
    n = (sz > 3'd4) ? 4 : int'(sz);
    first = 0;
    @(negedge clk);
    write_addr = a; write_data = d; bytes_to_write = sz; write_activate = 1'b1;
    if (n == 0) begin
      for (int c = 0; c < 2; c++) begin
        @(posedge clk); #1;
        check({tag, " noop_done"}, {31'd0, write_done}, 32'd0);
      end
    end else begin
      for (int c = 1; c <= 4 && first == 0; c++) begin
        @(posedge clk); #1;
        if (write_done) first = c;
      end
      check({tag, " done_latency"}, first, 32'd1);
      model_write(a, d, n);
    end
    @(negedge clk);
    write_activate = 1'b0;
    @(posedge clk); #1;
    check({tag, " done_drop"}, {31'd0, write_done}, 32'd0);
  endtask

  task automatic check_reads(input logic [31:0] ia, input logic [31:0] fa, input string tag);
    instruction_addr = ia;
    fetch_addr       = fa;
    #1;
    check({tag, " ifetch"}, instruction_data, model_word(ia));
    check({tag, " load"},   fetched_data,     model_word(fa));
  endtask

  initial begin
    rst = 1'b1; write_activate = 1'b0; bytes_to_write = 3'd0;
    write_addr = 32'd0; write_data = 32'd0;
    instruction_addr = 32'h100; fetch_addr = 32'h104;
    repeat (3) @(posedge clk);
    #1;
    check("reset done", {31'd0, write_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Give every byte a known value so the model fully covers the array.
    for (int i = 0; i < DEPTH / 4; i++) do_write(32'(i * 4), $urandom, 3'd4, "init");

    do_write(32'h100, 32'hffff_ffff, 3'd4, "w_ff");
    check_reads(32'h100, 32'h104, "w_ff");
    check("w_ff const", instruction_data, 32'hffff_ffff);

    @(negedge clk);
    @(posedge clk); #1;
    check("idle done", {31'd0, write_done}, 32'd0);
    check("idle data", instruction_data, 32'hffff_ffff);

    do_write(32'h100, 32'h0, 3'd1, "sz1");
    #1 check("sz1 const", instruction_data, 32'hffff_ff00);
    do_write(32'h100, 32'h0, 3'd2, "sz2");
    #1 check("sz2 const", instruction_data, 32'hffff_0000);
    do_write(32'h100, 32'h0, 3'd4, "sz4");
    #1 check("sz4 const", instruction_data, 32'h0000_0000);

    do_write(32'h104, 32'hdead_beef, 3'd4, "w_beef");
    #1 check("w_beef const", fetched_data, 32'hdead_beef);
    do_write(32'h104, 32'hb0ba_cafe, 3'd2, "w_cafe");
    #1 check("w_cafe const", fetched_data, 32'hdead_cafe);
    check_reads(32'h100, 32'h104, "half");

    do_write(32'h100, 32'h0, 3'd4, "clr");
    do_write(32'h101, 32'haabb_ccdd, 3'd4, "unal");
    check_reads(32'h100, 32'h101, "unal");
    check("unal const", instruction_data, 32'hbbcc_dd00);

    // Image at 0x0..0xf, then reset with a pending request that must be dropped.
    do_write(32'h0, 32'hdead_beef, 3'd4, "img0");
    do_write(32'h4, 32'haabb_ccdd, 3'd4, "img1");
    do_write(32'h8, 32'hffff_ffff, 3'd4, "img2");
    do_write(32'hc, 32'h0000_0000, 3'd4, "img3");
    @(negedge clk);
    rst = 1'b1; write_activate = 1'b1; write_addr = 32'h0;
    write_data = 32'h1234_5678; bytes_to_write = 3'd4;
    instruction_addr = 32'h0; fetch_addr = 32'h4;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst done", {31'd0, write_done}, 32'd0);
      check("rst read", instruction_data, 32'hdead_beef);
    end
    @(negedge clk);
    rst = 1'b0; write_activate = 1'b0;
    #1;
    check("img 0", instruction_data, 32'hdead_beef);
    check("img 4", fetched_data, 32'haabb_ccdd);
    fetch_addr = 32'h8; #1 check("img 8", fetched_data, 32'hffff_ffff);
    fetch_addr = 32'hc; #1 check("img c", fetched_data, 32'h0000_0000);

    // Held request: commits every second cycle; data changes in DONE ignored.
    @(negedge clk);
    write_addr = 32'h200; write_data = 32'h0102_0304; bytes_to_write = 3'd4;
    write_activate = 1'b1; instruction_addr = 32'h200;
    @(posedge clk); #1;
    check("hold done1", {31'd0, write_done}, 32'd1);
    @(negedge clk);
    write_data = 32'ha5a5_5a5a;
    @(posedge clk); #1;
    check("hold done2", {31'd0, write_done}, 32'd0);
    check("hold ignored", instruction_data, 32'h0102_0304);
    @(posedge clk); #1;
    check("hold done3", {31'd0, write_done}, 32'd1);
    check("hold recommit", instruction_data, 32'ha5a5_5a5a);
    @(negedge clk);
    write_activate = 1'b0;
    model_write(32'h200, 32'ha5a5_5a5a, 4);
    @(posedge clk); #1;
    check("hold done4", {31'd0, write_done}, 32'd0);

    do_write(DEPTH - 2, 32'h1122_3344, 3'd4, "wrap");
    instruction_addr = DEPTH - 2; fetch_addr = 32'h0; #1;
    check("wrap top", instruction_data, 32'h1122_3344);
    check("wrap low", {16'd0, fetched_data[15:0]}, 32'h0000_1122);
    check_reads(32'hffff_fffe, 32'h0000_1fff, "wrap alias");

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom;
      do_write(a, $urandom, 3'($urandom_range(0, 7)), "rand_w");
      check_reads(a, a - 32'($urandom_range(0, 3)), "rand_r");
      check_reads($urandom, $urandom, "rand_any");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
